// File: rtl/kdf_run_pkg.sv
// Shared widths and state encoding for the KDF run sequencer.
package kdf_run_pkg;

  localparam int SALT_W  = 64;
  localparam int COUNT_W = 32;
  localparam int PWD_W   = 32;
  localparam int KEY_W   = 128;
  localparam int CYC_W   = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_RST = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } run_state_e;

endpackage

// File: rtl/kdf_run_sequencer_counter.sv
// Free-running cycle counter with synchronous clear and count enable.
module run_cycle_counter
  import kdf_run_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] count
);

  // Clear has priority over enable so a new phase always starts at zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CYC_W'(1);
    end
  end

endmodule

// File: rtl/kdf_run_sequencer.sv
// Sequences one measured KDF run: parameter latch, UUT reset hold,
// cycle-counted run with timeout, and result capture.
//
// state    | meaning
// IDLE     | waiting for start, UUT held in reset
// HOLD_RST | UUT held in reset for RST_CYCLES cycles
// RUN      | UUT released, counting cycles until end or timeout
// DONE     | one-cycle completion pulse, then back to IDLE
module kdf_run_sequencer
  import kdf_run_pkg::*;
#(
  parameter int unsigned      RST_CYCLES     = 16,
  parameter logic [CYC_W-1:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [SALT_W-1:0]  salt_in,
  input  logic [COUNT_W-1:0] count_in,
  input  logic [PWD_W-1:0]   password_in,
  output logic               busy,
  output logic               done,
  output logic               valid,
  output logic               timeout,
  output logic [KEY_W-1:0]   key_out,
  output logic [CYC_W-1:0]   cycles_out,
  output logic               rst_uut,
  output logic [SALT_W-1:0]  salt_uut,
  output logic [COUNT_W-1:0] count_uut,
  output logic [PWD_W-1:0]   password_uut,
  input  logic [KEY_W-1:0]   key_derivated_uut,
  input  logic               end_signal_uut
);

  localparam logic [CYC_W-1:0] HOLD_LAST = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] RUN_LAST  = TIMEOUT_CYCLES - CYC_W'(1);

  run_state_e       state, state_nxt;
  logic [CYC_W-1:0] hold_cnt, run_cnt;
  logic             accept, hold_en, run_clr, run_en, cap_end, cap_tmo;

  run_cycle_counter u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (hold_en),
    .count (hold_cnt)
  );

  run_cycle_counter u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (run_clr),
    .en    (run_en),
    .count (run_cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, status outputs and counter/capture strobes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rst_uut   = 1'b1;
    accept    = 1'b0;
    hold_en   = 1'b0;
    run_clr   = 1'b0;
    run_en    = 1'b0;
    cap_end   = 1'b0;
    cap_tmo   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = HOLD_RST;
        end
      end
      HOLD_RST: begin
        busy    = 1'b1;
        hold_en = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          run_clr   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        rst_uut = 1'b0;
        if (abort) begin
          state_nxt = IDLE;
        end else if (end_signal_uut) begin
          cap_end   = 1'b1;
          state_nxt = DONE;
        end else if (run_cnt == RUN_LAST) begin
          cap_tmo   = 1'b1;
          state_nxt = DONE;
        end else begin
          run_en = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Parameter latch on accept; result capture on end or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      salt_uut     <= '0;
      count_uut    <= '0;
      password_uut <= '0;
      key_out      <= '0;
      cycles_out   <= '0;
      valid        <= 1'b0;
      timeout      <= 1'b0;
    end else if (accept) begin
      salt_uut     <= salt_in;
      count_uut    <= count_in;
      password_uut <= password_in;
      key_out      <= '0;
      cycles_out   <= '0;
      valid        <= 1'b0;
      timeout      <= 1'b0;
    end else if (cap_end) begin
      key_out    <= key_derivated_uut;
      cycles_out <= run_cnt;
      valid      <= 1'b1;
    end else if (cap_tmo) begin
      cycles_out <= TIMEOUT_CYCLES;
      timeout    <= 1'b1;
      valid      <= 1'b1;
    end
  end

endmodule
